// File: rtl/lcd_timing_pkg.sv
// Shared timing constants for the 800x480 RGB panel and the sync polarity helper.
package lcd_timing_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned H_FRONT  = 40;
    localparam int unsigned H_SYNC   = 48;
    localparam int unsigned H_BACK   = 40;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 13;
    localparam int unsigned V_SYNC   = 3;
    localparam int unsigned V_BACK   = 29;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Pin level of a sync signal given whether it is asserted and its polarity.
    function automatic logic sync_level(input logic asserted, input logic act_low);
        return asserted ^ act_low;
    endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// Wrap counter: counts 0..MAX on each inc, flags the increment that wraps to zero.
module lcd_sync_counter #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned MAX   = 927
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == MAX_C);
    assign wrap   = inc && at_max;
    assign cnt    = cnt_q;

    // Next count: hold, increment, or return to zero after MAX
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = at_max ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_800_480_timing.sv
// Display timing generator for the 800x480 RGB LCD, pixel clock domain.
// Outputs are registered one ce-cycle behind the h/v counters and hold while ce=0.
module lcd_800_480_timing #(
    parameter int unsigned H_ACTIVE      = lcd_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FRONT       = lcd_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC        = lcd_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK        = lcd_timing_pkg::H_BACK,
    parameter int unsigned V_ACTIVE      = lcd_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FRONT       = lcd_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC        = lcd_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK        = lcd_timing_pkg::V_BACK,
    parameter bit          HSYNC_ACT_LOW = 1'b1,
    parameter bit          VSYNC_ACT_LOW = 1'b1,
    parameter int unsigned X_WIDTH       = 10,
    parameter int unsigned Y_WIDTH       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    import lcd_timing_pkg::*;

    // Line/frame lengths and region bounds for this instance's timing
    localparam int unsigned H_PERIOD   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_PERIOD   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FRONT;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FRONT;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

    localparam logic [X_WIDTH-1:0] H_ACT_C = X_WIDTH'(H_ACTIVE);
    localparam logic [X_WIDTH-1:0] H_SB_C  = X_WIDTH'(H_SYNC_BEG);
    localparam logic [X_WIDTH-1:0] H_SE_C  = X_WIDTH'(H_SYNC_END);
    localparam logic [Y_WIDTH-1:0] V_ACT_C = Y_WIDTH'(V_ACTIVE);
    localparam logic [Y_WIDTH-1:0] V_SB_C  = Y_WIDTH'(V_SYNC_BEG);
    localparam logic [Y_WIDTH-1:0] V_SE_C  = Y_WIDTH'(V_SYNC_END);

    logic [X_WIDTH-1:0] h_cnt;
    logic [Y_WIDTH-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;

    lcd_sync_counter #(
        .WIDTH (X_WIDTH),
        .MAX   (H_PERIOD - 1)
    ) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ce),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    lcd_sync_counter #(
        .WIDTH (Y_WIDTH),
        .MAX   (V_PERIOD - 1)
    ) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ce & h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    // The frame can only end on the last pixel of a line
    a_wrap_aligned: assert property (@(posedge clk) disable iff (!rst_n) v_wrap |-> h_wrap);

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic               ls_q, ls_d;
    logic               fs_q, fs_d;
    logic               h_act;
    logic               v_act;

    // Decode the current counter position into the next output values
    always_comb begin
        h_act   = (h_cnt < H_ACT_C);
        v_act   = (v_cnt < V_ACT_C);
        de_d    = h_act && v_act;
        x_d     = de_d ? h_cnt : '0;
        y_d     = de_d ? v_cnt : '0;
        hsync_d = sync_level((h_cnt >= H_SB_C) && (h_cnt < H_SE_C), HSYNC_ACT_LOW);
        vsync_d = sync_level((v_cnt >= V_SB_C) && (v_cnt < V_SE_C), VSYNC_ACT_LOW);
        ls_d    = (h_cnt == '0) && v_act;
        fs_d    = (h_cnt == '0) && (v_cnt == '0);
    end

    // Output register: inactive levels in reset, update only on ce cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q <= sync_level(1'b0, HSYNC_ACT_LOW);
            vsync_q <= sync_level(1'b0, VSYNC_ACT_LOW);
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (ce) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_800_480_timing.sv
// Scoreboard bench: the stimulus process predicts each output from a pixel-index
// model and queues it; the monitor pops and compares after every clock edge.
module tb_lcd_800_480_timing;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct packed {
        int unsigned ha, hf, hs, hb;
        int unsigned va, vf, vs, vb;
        bit          hlow, vlow;
    } cfg_t;

    localparam cfg_t BIG = '{ha: 800, hf: 40, hs: 48, hb: 40,
                             va: 480, vf: 13, vs: 3,  vb: 29,
                             hlow: 1'b1, vlow: 1'b1};
    localparam cfg_t SML = '{ha: 8, hf: 2, hs: 3, hb: 2,
                             va: 5, vf: 1, vs: 2, vb: 3,
                             hlow: 1'b0, vlow: 1'b0};

    logic clk = 1'b0;
    logic rst_n;
    logic ce;

    logic       b_hsync, b_vsync, b_de, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic       s_hsync, s_vsync, s_de, s_ls, s_fs;
    logic [3:0] s_x, s_y;

    always #5 clk = ~clk;

    lcd_800_480_timing dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .display_on  (b_de),
        .x           (b_x),
        .y           (b_y),
        .line_start  (b_ls),
        .frame_start (b_fs)
    );

    lcd_800_480_timing #(
        .H_ACTIVE      (8),
        .H_FRONT       (2),
        .H_SYNC        (3),
        .H_BACK        (2),
        .V_ACTIVE      (5),
        .V_FRONT       (1),
        .V_SYNC        (2),
        .V_BACK        (3),
        .HSYNC_ACT_LOW (1'b0),
        .VSYNC_ACT_LOW (1'b0),
        .X_WIDTH       (4),
        .Y_WIDTH       (4)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .display_on  (s_de),
        .x           (s_x),
        .y           (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs)
    );

    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    out_t q_big[$];
    out_t q_sml[$];
    int unsigned p_big = 0;
    int unsigned p_sml = 0;
    out_t last_big;
    out_t last_sml;

    function automatic int unsigned line_len(cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int unsigned frame_len(cfg_t c);
        return line_len(c) * (c.va + c.vf + c.vs + c.vb);
    endfunction

    // Expected outputs for the pixel at linear position p of the frame
    function automatic out_t model(cfg_t c, int unsigned p);
        out_t o;
        int unsigned h;
        int unsigned v;
        h    = p % line_len(c);
        v    = p / line_len(c);
        o.de = (h < c.ha) && (v < c.va);
        o.x  = o.de ? 10'(h) : 10'd0;
        o.y  = o.de ? 10'(v) : 10'd0;
        o.hs = ((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs)) ^ c.hlow;
        o.vs = ((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs)) ^ c.vlow;
        o.ls = (h == 0) && (v < c.va);
        o.fs = (p == 0);
        return o;
    endfunction

    function automatic out_t idle(cfg_t c);
        out_t o;
        o    = '0;
        o.hs = c.hlow;
        o.vs = c.vlow;
        return o;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                         o.hs, o.vs, o.de, o.x, o.y, o.ls, o.fs);
    endfunction

    task automatic predict(input bit r, input bit c);
        if (!r) begin
            p_big    = 0;
            p_sml    = 0;
            last_big = idle(BIG);
            last_sml = idle(SML);
        end else if (c) begin
            last_big = model(BIG, p_big);
            last_sml = model(SML, p_sml);
            p_big    = (p_big + 1) % frame_len(BIG);
            p_sml    = (p_sml + 1) % frame_len(SML);
        end
        q_big.push_back(last_big);
        q_sml.push_back(last_sml);
    endtask

    task automatic cycle(input bit r, input bit c);
        @(negedge clk);
        rst_n = r;
        ce    = c;
        predict(r, c);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got {%s}, expected {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    // Monitor: per-edge scoreboard compare plus waveform-shape measurements
    initial begin
        bit   adv, rs;
        out_t exp_o;
        int   b_since = 0, b_hs_run = 0, b_de_run = 0;
        bit   b_ls_seen = 1'b0;
        int   s_fs_cnt = 0, s_ls_cnt = 0, s_vs_run = 0, s_de_run = 0;
        bit   s_fs_seen = 1'b0;
        while (!done) begin
            @(posedge clk);
            adv = rst_n && ce;
            rs  = !rst_n;
            #1;
            if (done) break;

            if (q_big.size() == 0) begin
                checks++; errors++;
                $display("FAIL big_queue @%0t: got empty queue, expected a prediction", $time);
            end else begin
                exp_o = q_big.pop_front();
                check_out("big_out", {b_hsync, b_vsync, b_de, b_x, b_y, b_ls, b_fs}, exp_o);
            end
            if (q_sml.size() == 0) begin
                checks++; errors++;
                $display("FAIL sml_queue @%0t: got empty queue, expected a prediction", $time);
            end else begin
                exp_o = q_sml.pop_front();
                check_out("sml_out", {s_hsync, s_vsync, s_de, 6'd0, s_x, 6'd0, s_y, s_ls, s_fs}, exp_o);
            end

            if (rs) begin
                b_since = 0; b_hs_run = 0; b_de_run = 0; b_ls_seen = 1'b0;
                s_fs_cnt = 0; s_ls_cnt = 0; s_vs_run = 0; s_de_run = 0; s_fs_seen = 1'b0;
            end else if (adv) begin
                // 800x480 instance: line-level shape
                b_since++;
                if (b_ls) begin
                    b_since   = 0;
                    b_ls_seen = 1'b1;
                end
                if (b_hsync == !BIG.hlow) begin
                    b_hs_run++;
                    if (b_hs_run == 1 && b_ls_seen)
                        check_int("big_hsync_onset", b_since, int'(BIG.ha + BIG.hf));
                end else if (b_hs_run > 0) begin
                    check_int("big_hsync_width", b_hs_run, int'(BIG.hs));
                    b_hs_run = 0;
                end
                if (b_de) begin
                    b_de_run++;
                end else if (b_de_run > 0) begin
                    check_int("big_de_width", b_de_run, int'(BIG.ha));
                    b_de_run = 0;
                end

                // Small instance: frame-level shape
                s_fs_cnt++;
                if (s_fs) begin
                    if (s_fs_seen) begin
                        check_int("sml_frame_period", s_fs_cnt, int'(frame_len(SML)));
                        check_int("sml_lines_per_frame", s_ls_cnt, int'(SML.va));
                    end
                    s_fs_seen = 1'b1;
                    s_fs_cnt  = 0;
                    s_ls_cnt  = 0;
                end
                if (s_ls) s_ls_cnt++;
                if (s_vsync == !SML.vlow) begin
                    s_vs_run++;
                end else if (s_vs_run > 0) begin
                    check_int("sml_vsync_width", s_vs_run, int'(SML.vs * line_len(SML)));
                    s_vs_run = 0;
                end
                if (s_de) begin
                    s_de_run++;
                end else if (s_de_run > 0) begin
                    check_int("sml_de_width", s_de_run, int'(SML.ha));
                    s_de_run = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit tog;
        int guard;
        rst_n = 1'b0;
        ce    = 1'b0;
        predict(1'b0, 1'b0);
        repeat (4) cycle(1'b0, bit'($urandom % 2));

        // Free run from reset
        repeat (2000) cycle(1'b1, 1'b1);

        // ce toggling every cycle
        tog = 1'b0;
        repeat (4000) begin
            tog = ~tog;
            cycle(1'b1, tog);
        end

        // Reset mid-line right after the pixel at x=400 has been output
        guard = 0;
        while ((p_big % line_len(BIG)) != 401 && guard < 3000) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        repeat (3) cycle(1'b0, bit'($urandom % 2));
        repeat (2) cycle(1'b1, 1'b0);

        // Random ce with occasional single-cycle resets
        repeat (25000) begin
            cycle(($urandom % 3000) != 0, ($urandom % 4) != 0);
        end

        @(posedge clk);
        #2;
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
